// File: rtl/serv_alu_seq_pkg.sv
// Shared definitions for the serial ALU sequencer.
//   seq_state_e : sequencer state encoding (IDLE/INIT/RUN)
//   SHAMT_BITS  : number of shift-amount bits loaded during the INIT phase
package serv_alu_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_INIT = 2'd1,
    SEQ_RUN  = 2'd2
  } seq_state_e;

  localparam int unsigned SHAMT_BITS = 5;

endpackage : serv_alu_seq_pkg

// File: rtl/serv_bit_cnt.sv
// Bit-position counter for serial units.
//   clk    : clock, rising edge
//   i_rst  : asynchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear, takes priority over i_inc
//   i_inc  : advance count by one
//   o_cnt  : current bit index
//   o_last : count is at WIDTH-1
module serv_bit_cnt #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule : serv_bit_cnt

// File: rtl/serv_alu_seq.sv
// Sequencer for the bit-serial ALU. Accepts one op over req/ack and drives
// the ALU enable/init/cnt_done/shamt_en strobes plus rd write-back gating.
//   clk, i_rst   : clock, asynchronous active-high reset
//   i_req/o_ack  : request handshake (transfer on i_req & o_ack)
//   i_two_phase  : op needs an INIT phase before RUN
//   i_shift      : op is a shift (shamt loaded during INIT)
//   i_flush      : abandon current op / block acceptance in IDLE
//   o_en, o_init, o_cnt_done, o_shamt_en : ALU strobes
//   o_cnt        : bit index within current phase
//   o_rd_en      : write-back enable (RUN only)
//   o_busy       : op in progress
//   o_done       : one-cycle pulse after the last RUN bit
module serv_alu_seq
  import serv_alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_req,
  output logic             o_ack,
  input  logic             i_two_phase,
  input  logic             i_shift,
  input  logic             i_flush,
  output logic             o_en,
  output logic             o_init,
  output logic             o_cnt_done,
  output logic             o_shamt_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_rd_en,
  output logic             o_busy,
  output logic             o_done
);

  seq_state_e state_q, state_d;
  logic       shift_q;
  logic       done_q, done_d;
  logic       xfer;
  logic       cnt_clr, cnt_inc, cnt_last;
  logic [CNT_W-1:0] cnt;

  serv_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_clr  (cnt_clr),
    .i_inc  (cnt_inc),
    .o_cnt  (cnt),
    .o_last (cnt_last)
  );

  // A flush in IDLE still shows ack but suppresses the transfer.
  assign xfer = (state_q == SEQ_IDLE) && i_req && !i_flush;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (xfer) begin
          state_d = i_two_phase ? SEQ_INIT : SEQ_RUN;
          cnt_clr = 1'b1;
        end
      end
      SEQ_INIT: begin
        if (i_flush) begin
          state_d = SEQ_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_last) begin
          state_d = SEQ_RUN;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (i_flush) begin
          state_d = SEQ_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_last) begin
          state_d = SEQ_IDLE;
          cnt_clr = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SEQ_IDLE;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // Shift flag only matters for two-phase ops, so fold that in here.
      if (xfer) begin
        shift_q <= i_shift & i_two_phase;
      end
    end
  end

  assign o_ack      = (state_q == SEQ_IDLE);
  assign o_busy     = (state_q != SEQ_IDLE);
  assign o_en       = o_busy;
  assign o_init     = (state_q == SEQ_INIT);
  assign o_rd_en    = (state_q == SEQ_RUN);
  assign o_cnt_done = o_busy && cnt_last;
  assign o_shamt_en = o_init && shift_q && (cnt < CNT_W'(SHAMT_BITS));
  assign o_cnt      = cnt;
  assign o_done     = done_q;

endmodule : serv_alu_seq

// File: tb/tb_serv_alu_seq.sv
module tb_serv_alu_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_req;
  logic             o_ack;
  logic             i_two_phase;
  logic             i_shift;
  logic             i_flush;
  logic             o_en;
  logic             o_init;
  logic             o_cnt_done;
  logic             o_shamt_en;
  logic [CNT_W-1:0] o_cnt;
  logic             o_rd_en;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  serv_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .o_ack       (o_ack),
    .i_two_phase (i_two_phase),
    .i_shift     (i_shift),
    .i_flush     (i_flush),
    .o_en        (o_en),
    .o_init      (o_init),
    .o_cnt_done  (o_cnt_done),
    .o_shamt_en  (o_shamt_en),
    .o_cnt       (o_cnt),
    .o_rd_en     (o_rd_en),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // Output vector order: {ack,en,init,cnt_done,shamt_en,rd_en,busy,done}
  function automatic logic [7:0] obs();
    return {o_ack, o_en, o_init, o_cnt_done, o_shamt_en, o_rd_en, o_busy, o_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = 1'b0; i_two_phase = 1'b0; i_shift = 1'b0; i_flush = 1'b0;
    #3;
    checks++;
    if (obs() !== 8'b1000_0000 || o_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got %b cnt %0d, want 10000000 cnt 0", obs(), o_cnt);
    end
    step(); step();
    i_rst = 1'b0;
    step();
  endtask

  // Single-phase: RUN cycles 1..32, done at 33.
  task automatic test_single_add();
    logic [7:0] exp;
    logic [CNT_W-1:0] ecnt;
    i_req = 1'b1; i_two_phase = 1'b0; i_shift = 1'b1;
    checks++;
    if (o_ack !== 1'b1) begin
      errors++;
      $display("FAIL add_ack: got %b want 1", o_ack);
    end
    step();
    i_req = 1'b0; i_shift = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c <= 32) begin
        exp  = {1'b0, 1'b1, 1'b0, (c == 32), 1'b0, 1'b1, 1'b1, 1'b0};
        ecnt = CNT_W'(c - 1);
      end else begin
        exp  = {1'b1, 6'b0, (c == 33)};
        ecnt = '0;
      end
      checks++;
      if (obs() !== exp || o_cnt !== ecnt) begin
        errors++;
        $display("FAIL add_cycle%0d: got %b cnt %0d, want %b cnt %0d", c, obs(), o_cnt, exp, ecnt);
      end
      step();
    end
  endtask

  // Shift: INIT 1..32 (shamt 1..5), RUN 33..64, done at 65.
  task automatic test_shift();
    logic [7:0] exp;
    logic [CNT_W-1:0] ecnt;
    i_req = 1'b1; i_two_phase = 1'b1; i_shift = 1'b1;
    step();
    i_req = 1'b0; i_two_phase = 1'b0; i_shift = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      if (c <= 32) begin
        exp  = {1'b0, 1'b1, 1'b1, (c == 32), (c <= 5), 1'b0, 1'b1, 1'b0};
        ecnt = CNT_W'(c - 1);
      end else if (c <= 64) begin
        exp  = {1'b0, 1'b1, 1'b0, (c == 64), 1'b0, 1'b1, 1'b1, 1'b0};
        ecnt = CNT_W'(c - 33);
      end else begin
        exp  = {1'b1, 6'b0, (c == 65)};
        ecnt = '0;
      end
      checks++;
      if (obs() !== exp || o_cnt !== ecnt) begin
        errors++;
        $display("FAIL shift_cycle%0d: got %b cnt %0d, want %b cnt %0d", c, obs(), o_cnt, exp, ecnt);
      end
      step();
    end
  endtask

  // Two-phase compare without shift: shamt_en must never rise.
  task automatic test_compare_no_shamt();
    int seen_shamt = 0;
    int seen_init = 0;
    i_req = 1'b1; i_two_phase = 1'b1; i_shift = 1'b0;
    step();
    i_req = 1'b0; i_two_phase = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      seen_shamt += int'(o_shamt_en);
      seen_init  += int'(o_init);
      step();
    end
    checks++;
    if (seen_shamt !== 0 || seen_init !== 32) begin
      errors++;
      $display("FAIL cmp_strobes: got shamt %0d init %0d, want shamt 0 init 32", seen_shamt, seen_init);
    end
  endtask

  // i_req held: second transfer in done cycle 33, second RUN 34..65, done 66.
  task automatic test_back_to_back();
    logic [7:0] exp;
    i_req = 1'b1; i_two_phase = 1'b0; i_shift = 1'b0;
    step();
    for (int c = 1; c <= 68; c++) begin
      if ((c >= 1 && c <= 32) || (c >= 34 && c <= 65))
        exp = {1'b0, 1'b1, 1'b0, (c == 32 || c == 65), 1'b0, 1'b1, 1'b1, 1'b0};
      else
        exp = {1'b1, 6'b0, (c == 33 || c == 66)};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %b, want %b", c, obs(), exp);
      end
      if (c == 34) i_req = 1'b0;
      step();
    end
  endtask

  // Request pulsed mid-op is dropped.
  task automatic test_busy_request();
    i_req = 1'b1; i_two_phase = 1'b0;
    step();
    i_req = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      if (c == 10) begin
        i_req = 1'b1;
        #1;
        checks++;
        if (o_ack !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_ack: got ack %b busy %b, want ack 0 busy 1", o_ack, o_busy);
        end
      end
      if (c == 11) i_req = 1'b0;
      if (c >= 34) begin
        checks++;
        if (o_busy !== 1'b0 || o_en !== 1'b0 || o_done !== 1'b0) begin
          errors++;
          $display("FAIL busy_dropped_cycle%0d: got busy %b en %b done %b, want 0 0 0", c, o_busy, o_en, o_done);
        end
      end
      step();
    end
  endtask

  // Flush at INIT cnt==31: IDLE next, no RUN, no done.
  task automatic test_flush();
    int rd_seen = 0;
    int done_seen = 0;
    i_req = 1'b1; i_two_phase = 1'b1; i_shift = 1'b0;
    step();
    i_req = 1'b0; i_two_phase = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      if (c == 32) begin
        checks++;
        if (o_cnt !== 5'd31 || o_init !== 1'b1) begin
          errors++;
          $display("FAIL flush_pre: got cnt %0d init %b, want 31 1", o_cnt, o_init);
        end
        i_flush = 1'b1;
      end
      if (c == 33) begin
        i_flush = 1'b0;
        checks++;
        if (obs() !== 8'b1000_0000 || o_cnt !== 5'd0) begin
          errors++;
          $display("FAIL flush_idle: got %b cnt %0d, want 10000000 cnt 0", obs(), o_cnt);
        end
      end
      rd_seen   += int'(o_rd_en);
      done_seen += int'(o_done);
      step();
    end
    checks++;
    if (rd_seen !== 0 || done_seen !== 0) begin
      errors++;
      $display("FAIL flush_no_run: got rd %0d done %0d, want 0 0", rd_seen, done_seen);
    end
  endtask

  // Flush in RUN, and flush coinciding with a request in IDLE.
  task automatic test_flush_run_idle();
    i_req = 1'b1; i_two_phase = 1'b0;
    step();
    i_req = 1'b0;
    step(); step(); step();
    i_flush = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_run: got busy %b done %b, want 0 0", o_busy, o_done);
    end
    i_req = 1'b1;
    #1;
    checks++;
    if (o_ack !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_ack: got %b want 1", o_ack);
    end
    step();
    i_req = 1'b0; i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: got busy %b en %b, want 0 0", o_busy, o_en);
    end
    step();
  endtask

  // Async reset at RUN cnt==17.
  task automatic test_reset_mid_run();
    int done_seen = 0;
    i_req = 1'b1; i_two_phase = 1'b0;
    step();
    i_req = 1'b0;
    for (int c = 1; c < 18; c++) step();
    checks++;
    if (o_cnt !== 5'd17 || o_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got cnt %0d rd %b, want 17 1", o_cnt, o_rd_en);
    end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_en !== 1'b0 || o_cnt !== 5'd0 || o_ack !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got en %b cnt %0d ack %b busy %b, want 0 0 1 0", o_en, o_cnt, o_ack, o_busy);
    end
    step();
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      done_seen += int'(o_done) + int'(o_en);
      step();
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL rst_after: got %0d done/en cycles, want 0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_shift();
    test_compare_no_shamt();
    test_back_to_back();
    test_busy_request();
    test_flush();
    test_flush_run_idle();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serv_alu_seq

// File: doc/serv_alu_seq.md
Name: serv_alu_seq

Overview:
Sequencer for the bit-serial ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU's enable, init, count-done and shift-amount-load strobes. Single-phase ops (add/sub/bool) get one WIDTH-cycle RUN phase. Two-phase ops (compare, set-less-than, shift) get a WIDTH-cycle INIT phase immediately followed by a WIDTH-cycle RUN phase. The block sits between the decode/control logic and the ALU and also gates the rd write-back.

Parameters:
WIDTH, 32, data width in bits = cycles per phase; power of two, >= 8
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req  in  1  operation request (valid)
o_ack  out  1  ready; a transfer occurs when i_req & o_ack
i_two_phase  in  1  op needs INIT phase; sampled at transfer
i_shift  in  1  op is a shift (load shamt during INIT); sampled at transfer; ignored unless i_two_phase
i_flush  in  1  abandon current op
o_en  out  1  ALU enable (to ALU i_en)
o_init  out  1  ALU init phase (to ALU i_init)
o_cnt_done  out  1  last bit of the current phase (to ALU i_cnt_done)
o_shamt_en  out  1  shift-amount register load enable (to ALU i_shamt_en)
o_cnt  out  CNT_W  bit index within the current phase
o_rd_en  out  1  rd write-back enable, RUN phase only
o_busy  out  1  op in progress (state != IDLE)
o_done  out  1  one-cycle pulse after the last RUN bit

Behaviour:
- States: IDLE, INIT, RUN. Moore outputs decoded from registered state and counter; no combinational path from i_req to any output except o_ack.
- Reset (async, i_rst=1): state=IDLE, cnt=0, latched flags=0, o_done=0. All outputs are 0 except o_ack=1.
- IDLE: o_ack=1.
  - On transfer: latch i_two_phase and i_shift, cnt<=0.
  - Next state is INIT if i_two_phase, else RUN.
  - While i_req=0: stay in IDLE.
- INIT:
  - o_en=1, o_init=1, o_rd_en=0.
  - o_shamt_en=1 while latched shift=1 and cnt<=4 (exactly 5 cycles, cnt 0..4).
  - cnt increments each cycle. At cnt==WIDTH-1: o_cnt_done=1, cnt<=0, next state RUN.
  - No gap cycle between INIT and RUN: the ALU uses the falling edge of init for the SLT result.
- RUN:
  - o_en=1, o_init=0, o_rd_en=1, o_shamt_en=0.
  - At cnt==WIDTH-1: o_cnt_done=1, cnt<=0, next state IDLE, o_done<=1 for exactly the following cycle.
- o_ack=0 in INIT and RUN; i_req is ignored (not queued) while busy.
- o_done is high in the first IDLE cycle after the op. A new transfer may occur in that same cycle (back-to-back ops, zero bubble).
- o_en drops to 0 in IDLE, which clears the ALU adder carries. The +1 generation for subtraction relies on the o_en rising edge, so every op starts from o_en=0 for at least one cycle.
- Latency (transfer in cycle 0):
  - Single-phase: RUN in cycles 1..WIDTH, o_done in cycle WIDTH+1.
  - Two-phase: INIT in cycles 1..WIDTH, RUN in cycles WIDTH+1..2*WIDTH, o_done in cycle 2*WIDTH+1.
- i_flush:
  - In INIT or RUN: next state IDLE, cnt<=0, no o_done pulse. Flush takes priority over the phase-end transition.
  - In IDLE: blocks acceptance that cycle; o_ack stays 1, but a coinciding i_req is not transferred.
- Counter wraps only via the phase-end rule; it never exceeds WIDTH-1.

Decomposition:
- Shared params header (alongside the existing ALU params): state encodings SEQ_IDLE=2'd0, SEQ_INIT=2'd1, SEQ_RUN=2'd2, plus SHAMT_BITS=5.
- One natural sub-module: serv_bit_cnt. It is a CNT_W-bit counter with clear and increment inputs and a combinational last flag (cnt==WIDTH-1), and is reusable by other serial units.

Test Plan:
- Reset mid-RUN: assert i_rst at cnt=17 -> state IDLE immediately (async), o_en=0, o_cnt=0, o_ack=1, no o_done after release.
- Single-phase add (i_two_phase=0) at cycle 0 -> o_en=1 and o_rd_en=1 for cycles 1..32, o_cnt_done only in cycle 32, o_init never 1, o_done=1 in cycle 33 only.
- Shift (i_two_phase=1, i_shift=1) -> o_init=1 for cycles 1..32, o_shamt_en=1 for cycles 1..5 only, o_rd_en=1 for cycles 33..64, o_cnt_done in cycles 32 and 64, o_done in cycle 65.
- Back-to-back: i_req held high with two single-phase ops -> second transfer in cycle 33 (the o_done cycle), o_en=0 in cycle 33, second RUN in cycles 34..65.
- Busy request: i_req pulsed in cycle 10 of a running op -> o_ack=0, request dropped, no extra op follows.
- Flush at INIT cnt==31 -> next cycle IDLE (not RUN), o_rd_en never asserted, o_done stays 0.
